// File: rtl/i2c_reg_bank.sv
// I2C target exposing NUM_REGS 8-bit registers at one device address.
// Supports a register pointer, auto-increment, repeated-start reads and a local host write port.
//
// state      | meaning
// S_IDLE     | ignoring the bus until the next START
// S_ADDR     | shifting in the address byte
// S_ACK_ADDR | driving ACK for a matched address
// S_PTR      | shifting in the register pointer byte
// S_ACK_PTR  | ACK (pointer in range) or NACK (out of range)
// S_WRITE    | shifting in a data byte
// S_ACK_WR   | driving ACK; register commits at the end of this bit
// S_READ     | shifting out register[ptr], MSB first
// S_RACK     | sampling the controller ACK/NACK
module i2c_reg_bank #(
    parameter int         FILTER_LEN = 4,
    parameter logic [6:0] DEV_ADDR   = 7'h70,
    parameter int         NUM_REGS   = 8,
    parameter logic [7:0] RESET_VAL  = 8'h00,
    parameter int         PTR_W      = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl_i,
    output logic                  scl_o,
    output logic                  scl_t,
    input  logic                  sda_i,
    output logic                  sda_o,
    output logic                  sda_t,
    input  logic                  host_wr_en,
    input  logic [PTR_W-1:0]      host_wr_addr,
    input  logic [7:0]            host_wr_data,
    output logic [8*NUM_REGS-1:0] regs_out,
    output logic                  bus_wr_strobe,
    output logic [PTR_W-1:0]      bus_wr_addr,
    output logic                  busy,
    output logic                  bus_active
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ACK_ADDR, S_PTR, S_ACK_PTR, S_WRITE, S_ACK_WR, S_READ, S_RACK
    } state_t;

    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_REGS - 1);

    logic [FILTER_LEN-1:0] scl_sh_q, scl_sh_d, sda_sh_q, sda_sh_d;
    logic                  scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    state_t                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            rx_q, rx_d;
    logic [6:0]            tx_q, tx_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d, ptr_inc;
    logic                  rw_q, rw_d, ptr_ok_q, ptr_ok_d, mack_q, mack_d;
    logic                  sda_o_q, sda_o_d, busy_q, busy_d, bus_active_q, bus_active_d;
    logic                  wr_strobe_q, wr_strobe_d;
    logic [PTR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [7:0]            regs_q [NUM_REGS];
    logic [7:0]            regs_d [NUM_REGS];
    logic                  scl_rise, scl_fall, start_det, stop_det, bus_we;

    // Filtered level only moves once every sample in the window agrees.
    always_comb begin
        scl_sh_d = {scl_sh_q[FILTER_LEN-2:0], scl_i};
        sda_sh_d = {sda_sh_q[FILTER_LEN-2:0], sda_i};
        scl_f_d  = scl_f_q;
        sda_f_d  = sda_f_q;
        if (&scl_sh_q)       scl_f_d = 1'b1;
        else if (~|scl_sh_q) scl_f_d = 1'b0;
        if (&sda_sh_q)       sda_f_d = 1'b1;
        else if (~|sda_sh_q) sda_f_d = 1'b0;
    end

    assign scl_rise  = ~scl_f_q & scl_f_d;
    assign scl_fall  = scl_f_q & ~scl_f_d;
    assign start_det = scl_f_q & scl_f_d & sda_f_q & ~sda_f_d;
    assign stop_det  = scl_f_q & scl_f_d & ~sda_f_q & sda_f_d;
    assign ptr_inc   = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        ptr_d        = ptr_q;
        rw_d         = rw_q;
        ptr_ok_d     = ptr_ok_q;
        mack_d       = mack_q;
        sda_o_d      = sda_o_q;
        busy_d       = busy_q;
        bus_active_d = bus_active_q;
        wr_strobe_d  = 1'b0;
        wr_addr_d    = wr_addr_q;
        bus_we       = 1'b0;

        if (start_det) begin
            state_d      = S_ADDR;
            bit_cnt_d    = '0;
            sda_o_d      = 1'b1;
            bus_active_d = 1'b1;
        end else if (stop_det) begin
            state_d      = S_IDLE;
            sda_o_d      = 1'b1;
            busy_d       = 1'b0;
            bus_active_d = 1'b0;
        end else begin
            if (scl_rise) begin
                case (state_q)
                    S_ADDR, S_PTR, S_WRITE: begin
                        rx_d      = {rx_q[6:0], sda_f_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    S_READ:  bit_cnt_d = bit_cnt_q + 4'd1;
                    S_RACK:  mack_d = sda_f_q;
                    default: ;
                endcase
            end
            if (scl_fall) begin
                case (state_q)
                    S_ADDR: if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if (rx_q[7:1] == DEV_ADDR) begin
                            state_d = S_ACK_ADDR;
                            sda_o_d = 1'b0;
                            busy_d  = 1'b1;
                            rw_d    = rx_q[0];
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                    S_ACK_ADDR, S_RACK: begin
                        if (state_q == S_RACK && mack_q) begin
                            state_d = S_IDLE;
                            sda_o_d = 1'b1;
                            busy_d  = 1'b0;
                        end else if (state_q == S_ACK_ADDR && !rw_q) begin
                            state_d = S_PTR;
                            sda_o_d = 1'b1;
                        end else begin
                            state_d = S_READ;
                            tx_d    = regs_q[ptr_q][6:0];
                            sda_o_d = regs_q[ptr_q][7];
                            ptr_d   = ptr_inc;
                        end
                    end
                    S_PTR: if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        state_d   = S_ACK_PTR;
                        ptr_ok_d  = ({1'b0, rx_q} < 9'(NUM_REGS));
                        if ({1'b0, rx_q} < 9'(NUM_REGS)) begin
                            ptr_d   = rx_q[PTR_W-1:0];
                            sda_o_d = 1'b0;
                        end
                    end
                    S_ACK_PTR: begin
                        sda_o_d = 1'b1;
                        state_d = ptr_ok_q ? S_WRITE : S_IDLE;
                        busy_d  = ptr_ok_q;
                    end
                    S_WRITE: if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        state_d   = S_ACK_WR;
                        sda_o_d   = 1'b0;
                    end
                    S_ACK_WR: begin
                        state_d     = S_WRITE;
                        sda_o_d     = 1'b1;
                        bus_we      = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = ptr_q;
                        ptr_d       = ptr_inc;
                    end
                    S_READ: begin
                        if (bit_cnt_q == 4'd8) begin
                            bit_cnt_d = '0;
                            state_d   = S_RACK;
                            sda_o_d   = 1'b1;
                        end else begin
                            sda_o_d = tx_q[6];
                            tx_d    = {tx_q[5:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Bus write is applied last so it wins a same-index collision with the host.
    always_comb begin
        regs_d = regs_q;
        if (host_wr_en && (int'(host_wr_addr) < NUM_REGS)) regs_d[host_wr_addr] = host_wr_data;
        if (bus_we) regs_d[ptr_q] = rx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sh_q     <= '1;
            sda_sh_q     <= '1;
            scl_f_q      <= 1'b1;
            sda_f_q      <= 1'b1;
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            ptr_q        <= '0;
            rw_q         <= 1'b0;
            ptr_ok_q     <= 1'b0;
            mack_q       <= 1'b1;
            sda_o_q      <= 1'b1;
            busy_q       <= 1'b0;
            bus_active_q <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            regs_q       <= '{default: RESET_VAL};
        end else begin
            scl_sh_q     <= scl_sh_d;
            sda_sh_q     <= sda_sh_d;
            scl_f_q      <= scl_f_d;
            sda_f_q      <= sda_f_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            ptr_q        <= ptr_d;
            rw_q         <= rw_d;
            ptr_ok_q     <= ptr_ok_d;
            mack_q       <= mack_d;
            sda_o_q      <= sda_o_d;
            busy_q       <= busy_d;
            bus_active_q <= bus_active_d;
            wr_strobe_q  <= wr_strobe_d;
            wr_addr_q    <= wr_addr_d;
            regs_q       <= regs_d;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
        assign regs_out[8*k +: 8] = regs_q[k];
    end

    assign scl_o         = 1'b1;
    assign scl_t         = 1'b1;
    assign sda_o         = sda_o_q;
    assign sda_t         = sda_o_q;
    assign bus_wr_strobe = wr_strobe_q;
    assign bus_wr_addr   = wr_addr_q;
    assign busy          = busy_q;
    assign bus_active    = bus_active_q;

endmodule

// File: doc/i2c_reg_bank.md
Name: i2c_reg_bank

Overview:
I2C target that exposes a bank of NUM_REGS 8-bit registers at one 7-bit device address. It is the parametrised successor of i2c_single_reg, adding a register pointer, auto-increment, repeated-start reads and a local host write port. It sits on the shared open-drain SCL/SDA bus next to i2c_master and i2c_slave. Register contents are also presented in parallel to local logic.

Parameters:
FILTER_LEN, 4, SCL/SDA glitch-filter depth in clk cycles (>=2)
DEV_ADDR, 7'h70, 7-bit I2C device address
NUM_REGS, 8, number of 8-bit registers (2..256); PTR_W = clog2(NUM_REGS)
RESET_VAL, 8'h00, reset value of every register

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
scl_i  in  1  SCL from bus
scl_o  out  1  SCL drive value; constant 1, no clock stretching
scl_t  out  1  SCL tristate; constant 1
sda_i  in  1  SDA from bus
sda_o  out  1  SDA drive value; 0 = pull low
sda_t  out  1  SDA tristate; equals sda_o
host_wr_en  in  1  local register write strobe
host_wr_addr  in  PTR_W  local write index
host_wr_data  in  8  local write data
regs_out  out  8*NUM_REGS  all registers flattened; reg k is bits [8k+7:8k]
bus_wr_strobe  out  1  one-cycle pulse when the bus writes a register
bus_wr_addr  out  PTR_W  index of that bus write
busy  out  1  transaction addressed to this device is in progress
bus_active  out  1  high between START and STOP on the bus

Behaviour:
- Reset is asynchronous and active-low, on clk and rst_n. While rst_n=0:
  - registers = RESET_VAL, ptr = 0, state = IDLE
  - sda_o = sda_t = 1; scl_o = scl_t = 1
  - bus_wr_strobe = 0, bus_wr_addr = 0, busy = 0, bus_active = 0
- Reset mid-transfer releases SDA immediately. The bank ignores the bus until the next START.
- Input filter:
  - Each line passes through a FILTER_LEN-deep shift register.
  - The filtered value changes only when all FILTER_LEN samples agree.
  - START = filtered SDA falls while filtered SCL = 1. STOP = filtered SDA rises while filtered SCL = 1.
  - Sample SDA on the filtered SCL rising edge. Change sda_o one clk after the filtered SCL falling edge.
- State machine: IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WRITE, ACK_WR, READ, RACK.
  - START from any state goes to ADDR (repeated start); the bit counter is cleared.
  - STOP from any state goes to IDLE; busy = 0.
  - ADDR: shift 8 bits. On a match, go to ACK_ADDR and drive ACK low for one SCL period. On a mismatch, go to IDLE without driving SDA.
  - After a write address: PTR. Byte received goes to ACK_PTR.
    - Byte < NUM_REGS: ptr = byte, ACK, then WRITE.
    - Byte >= NUM_REGS: NACK, ptr unchanged, then IDLE.
  - WRITE: byte received, then ACK_WR.
    - Register[ptr] is updated at the ACK's SCL falling edge.
    - bus_wr_strobe pulses one clk with bus_wr_addr = ptr.
    - ptr increments, wrapping NUM_REGS-1 -> 0. Then back to WRITE.
  - After a read address: READ.
    - Shift register loads register[ptr] at the ACK_ADDR / RACK SCL falling edge. That is the value transmitted.
    - ptr increments and wraps on load.
    - MSB first; a 1 bit means SDA is released.
  - RACK: sample the controller's bit. ACK (0) returns to READ. NACK (1) releases SDA and goes to IDLE until STOP/START.
- busy = 1 from address match to STOP / mismatch / NACK. bus_active follows START/STOP regardless of address.
- Host port:
  - host_wr_en writes register[host_wr_addr] on the next clk edge.
  - If a bus write targets the same register in the same cycle, the bus write wins. A host write to a different index in the same cycle also completes.
  - host_wr_addr >= NUM_REGS is ignored.
- regs_out is registered and updates on the clk after the write.
- General call (address 0) is not acknowledged.

Test Plan:
- Write pointer: START, 0x70+W, ptr 0x03, data 0x55, STOP -> three ACKs; regs_out[31:24]=0x55; bus_wr_strobe one pulse with bus_wr_addr=3.
- Burst with wrap, NUM_REGS=8: ptr 6, data 0xA1,0xA2,0xA3 -> reg6=0xA1, reg7=0xA2, reg0=0xA3; three strobes at addrs 6,7,0.
- Repeated-start read after host writes reg2=0x7B, reg3=0xC4: write ptr 2, then Sr + 0x70+R, read 2 bytes (ACK, then NACK), STOP -> controller receives 0x7B, 0xC4; SDA released after the NACK.
- Invalid/foreign address: 0x42+W -> no ACK, busy stays 0, bus_active=1 until STOP. Ptr 0x09 on NUM_REGS=8 -> NACK; registers unchanged.
- Collision: host_wr_en to reg5=0x11 in the same clk as a bus write of 0x22 to reg5 -> reg5=0x22. Host write to reg4 in the same clk -> reg4 updated.
- Reset mid-read: assert rst_n=0 while driving a 0 bit -> sda_o=1 immediately; all regs = RESET_VAL; next transaction ACKs normally.
